pedest_signal: RTL
==================

// Module: pedest_signal
// PURPOSE
//  Memory-mapped pedestrian WALK/DON'T-WALK output device; the CPU-driven counterpart of the pedestrian-button input device.
//  Same CSR/DR model: the CPU enables the device via CSR, writes DR bit0=1 to request a crossing, and polls CSR.DBA or takes irq.
//  The device times a WALK phase, then a flashing DON'T-WALK phase, then returns to steady DON'T-WALK and sets DBA (done).
//  Sits on the CPU I/O bus beside the other device CSR/DR pairs.
// PARAMETERS
//  WALK_TICKS    50  cycles WALK is held (>=1)
//  FLASH_TICKS   20  cycles of the flashing DON'T-WALK phase (>=1)
//  FLASH_PERIOD   4  cycles per dont_walk level while flashing (half-period, >=1)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  CSR_in     in   8  CSR write data from CPU
//  CSR_wr     in   1  1-cycle strobe: load CSR from CSR_in
//  DR_in      in   8  DR write data; only bit0 is used (1 = request crossing)
//  DR_wr      in   1  1-cycle strobe: DR write
//  CSR_out    out  8  CSR readback {3'b0,EN,IE,DBA,OF,BUSY}
//  walk       out  1  WALK lamp
//  dont_walk  out  1  DON'T-WALK lamp
//  irq        out  1  interrupt request, level
// BEHAVIOUR
//  CSR bits: [4] EN device enable; [3] IE interrupt enable; [2] DBA done/buffer available;
//   [1] OF overrun; [0] BUSY read-only, 1 in WALK/FLASH; [7:5] read 0.
//  Reset: state IDLE, CSR=8'h00, walk=0, dont_walk=1, irq=0, counters 0.
//  CSR_wr: EN,IE,DBA,OF <= CSR_in[4:1]; CSR_in[0] ignored. A hardware DBA/OF set in the same cycle wins over a written 0.
//  irq = IE & DBA, combinational from registered CSR bits.
//  FSM: IDLE -> WALK -> FLASH -> IDLE.
//   IDLE:  walk=0, dont_walk=1. DR_wr & DR_in[0] & EN -> WALK next cycle.
//          On that edge: counter <= WALK_TICKS-1, BUSY=1, DBA=0. Latency: walk=1 on the cycle after DR_wr.
//   WALK:  walk=1, dont_walk=0 for exactly WALK_TICKS cycles. At counter 0 -> FLASH.
//          On that edge: counter <= FLASH_TICKS-1; phase counter <= FLASH_PERIOD-1.
//   FLASH: walk=0. dont_walk starts at 1 and inverts every FLASH_PERIOD cycles, for exactly FLASH_TICKS cycles.
//          At counter 0 -> IDLE. On that edge: dont_walk=1, BUSY=0, DBA=1.
//  EN, OF, DR_wr and CSR_wr:
//   DR_wr, DR_in[0], BUSY=1: ignored, OF<=1; phase timing unaffected.
//   DR_wr, EN=0 or DR_in[0]=0 in IDLE: no effect, no flag.
//   DR_wr is evaluated against the EN value registered before any same-cycle CSR_wr.
//   EN cleared by CSR_wr while BUSY: abort to IDLE next cycle; walk=0, dont_walk=1, BUSY=0, DBA not set, OF unchanged.
//  Widths: counters are $clog2(max(WALK_TICKS,FLASH_TICKS,FLASH_PERIOD)+1) bits. No wrap; counters reload only on state entry.
//  rst asserted mid-phase: returns to reset values on the next edge regardless of state.
// TESTING (WALK_TICKS=4, FLASH_TICKS=4, FLASH_PERIOD=2)
//  1. Normal cycle. rst; CSR_wr 0x18; DR_wr 0x01 at cycle t
//     -> walk=1 at t+1..t+4
//     -> t+5..t+8: walk=0, dont_walk 1,1,0,0
//     -> t+9: dont_walk=1, CSR_out=0x1C, irq=1.
//  2. Overrun. DR_wr 0x01 at t+2 of test 1 -> CSR_out[1]=1 from t+3; walk still ends after t+4; final CSR_out=0x1E.
//  3. Disabled device. CSR_wr 0x08 (EN=0); DR_wr 0x01 -> walk stays 0, dont_walk=1, CSR_out=0x08, irq=0.
//  4. Abort mid-WALK. At t+2 of test 1, CSR_wr 0x08 -> t+3: walk=0, dont_walk=1, CSR_out=0x08, irq=0.
//  5. Clear DBA. After test 1, CSR_wr 0x18 -> CSR_out=0x18, irq=0.
//     CSR_wr 0x10 in the same cycle as the FLASH->IDLE edge -> DBA=1 (hardware wins).
//  6. Reset mid-FLASH. rst at t+6 -> next cycle walk=0, dont_walk=1, CSR_out=0x00, irq=0.

Source files
------------

// File: rtl/pedest_signal.sv
// Memory-mapped pedestrian WALK / DON'T-WALK lamp controller with a CSR/DR register pair.
// The CPU requests a crossing through DR; the device times WALK, then flashing DON'T-WALK, then reports done.
module pedest_signal #(
  parameter int WALK_TICKS   = 50,
  parameter int FLASH_TICKS  = 20,
  parameter int FLASH_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] CSR_in,
  input  logic       CSR_wr,
  input  logic [7:0] DR_in,
  input  logic       DR_wr,
  output logic [7:0] CSR_out,
  output logic       walk,
  output logic       dont_walk,
  output logic       irq
);

  localparam int MAX_WF = (WALK_TICKS > FLASH_TICKS) ? WALK_TICKS : FLASH_TICKS;
  localparam int MAX_T  = (MAX_WF > FLASH_PERIOD) ? MAX_WF : FLASH_PERIOD;
  localparam int CW     = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] WALK_LOAD  = CW'(WALK_TICKS - 1);
  localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_TICKS - 1);
  localparam logic [CW-1:0] PHASE_LOAD = CW'(FLASH_PERIOD - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_FLASH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] phase_q, phase_d;
  logic          dw_q, dw_d;
  logic          en_q, en_d;
  logic          ie_q, ie_d;
  logic          dba_q, dba_d;
  logic          of_q, of_d;

  logic busy;
  logic req;
  logic abort;
  logic unused_bits;

  assign busy  = (state_q != S_IDLE);
  assign req   = DR_wr & DR_in[0];
  // Clearing EN through a CSR write cancels a crossing in progress.
  assign abort = busy & CSR_wr & ~CSR_in[4];

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    dw_d    = dw_q;
    en_d    = en_q;
    ie_d    = ie_q;
    dba_d   = dba_q;
    of_d    = of_q;

    if (CSR_wr) {en_d, ie_d, dba_d, of_d} = CSR_in[4:1];

    // Hardware updates come after the CSR write so a same-cycle hardware set wins.
    if (busy && req) of_d = 1'b1;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req && en_q) begin
            state_d = S_WALK;
            cnt_d   = WALK_LOAD;
            dba_d   = 1'b0;
          end
        end
        S_WALK: begin
          if (cnt_q == '0) begin
            state_d = S_FLASH;
            cnt_d   = FLASH_LOAD;
            phase_d = PHASE_LOAD;
            dw_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        S_FLASH: begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            dba_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
          end
          if (phase_q == '0) begin
            phase_d = PHASE_LOAD;
            dw_d    = ~dw_q;
          end else begin
            phase_d = phase_q - ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      dw_q    <= 1'b1;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      dba_q   <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      dw_q    <= dw_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      dba_q   <= dba_d;
      of_q    <= of_d;
    end
  end

  assign walk      = (state_q == S_WALK);
  assign dont_walk = (state_q == S_IDLE) | ((state_q == S_FLASH) & dw_q);
  assign CSR_out   = {3'b000, en_q, ie_q, dba_q, of_q, busy};
  assign irq       = ie_q & dba_q;

  assign unused_bits = ^{DR_in[7:1], CSR_in[7:5], CSR_in[0]};

endmodule
